// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step clock-enable controller for the emulated AES core, with reset-release sequencing.
// Optional enabled-cycle counter on cycle_count when CLK_CTRL_CYCLE_CNT_EN is defined (tied to 0 otherwise).
module clk_step_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [CNT_W-1:0] step_count,
  output logic             core_rst_n,
  output logic             core_clk_en,
  output logic             busy,
  output logic             step_done,
  output logic [1:0]       state,
  output logic [31:0]      cycle_count
);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_HALTED   = 2'd1,
    S_RUNNING  = 2'd2,
    S_STEPPING = 2'd3
  } state_e;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        sync_q, sync_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              clk_en_q, clk_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rst_sync;

  assign rst_sync = sync_q[1];

  always_comb begin
    sync_d       = {sync_q[0], 1'b1};
    state_d      = state_q;
    hold_d       = hold_q;
    step_d       = step_q;
    core_rst_n_d = core_rst_n_q;
    clk_en_d     = clk_en_q;
    done_d       = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (rst_sync) begin
          if (hold_q == '0) begin
            state_d      = S_HALTED;
            core_rst_n_d = 1'b1;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      S_HALTED: begin
        // halt_req outranks the others even when it has nothing to stop
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (step_req && (step_count != '0)) begin
          state_d  = S_STEPPING;
          step_d   = step_count - 1'b1;
          clk_en_d = 1'b1;
        end else if (run_req) begin
          state_d  = S_RUNNING;
          clk_en_d = 1'b1;
        end
      end
      S_RUNNING: begin
        if (halt_req) begin
          state_d  = S_HALTED;
          clk_en_d = 1'b0;
        end
      end
      S_STEPPING: begin
        // step_q holds the enabled cycles still owed after the current one
        if (halt_req) begin
          state_d  = S_HALTED;
          clk_en_d = 1'b0;
          step_d   = '0;
        end else if (step_q == '0) begin
          state_d  = S_HALTED;
          clk_en_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase

    busy_d = (state_d == S_RUNNING) || (state_d == S_STEPPING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b00;
      state_q      <= S_HOLD;
      hold_q       <= HOLD_INIT;
      step_q       <= '0;
      core_rst_n_q <= 1'b0;
      clk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      step_q       <= step_d;
      core_rst_n_q <= core_rst_n_d;
      clk_en_q     <= clk_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign core_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign step_done   = done_q;
  assign state       = state_q;

`ifdef CLK_CTRL_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  assign cyc_d = cyc_q + {31'b0, clk_en_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl: enabled-cycle budget model compared every cycle plus directed literal checks.
module tb_clk_step_ctrl;

  localparam int HOLD = 16;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_req = 1'b0;
  logic          halt_req = 1'b0;
  logic          step_req = 1'b0;
  logic [CW-1:0] step_count = '0;
  logic          core_rst_n;
  logic          core_clk_en;
  logic          busy;
  logic          step_done;
  logic [1:0]    state;
  logic [31:0]   cycle_count;

  clk_step_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .step_count  (step_count),
    .core_rst_n  (core_rst_n),
    .core_clk_en (core_clk_en),
    .busy        (busy),
    .step_done   (step_done),
    .state       (state),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: edges since release, free-run flag and remaining enabled-cycle budget.
  int          m_edges = 0;
  bit          m_out = 1'b0;
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_cc = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0;
      m_out   = 1'b0;
      m_run   = 1'b0;
      m_left  = 0;
      m_done  = 1'b0;
      m_cc    = '0;
    end else begin
      if (m_run || m_left > 0) m_cc = m_cc + 32'd1;
      m_done = 1'b0;
      if (!m_out) begin
        m_edges++;
        if (m_edges >= 2 + HOLD) m_out = 1'b1;
      end else if (m_run) begin
        if (halt_req) m_run = 1'b0;
      end else if (m_left > 0) begin
        if (halt_req) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end else if (!halt_req) begin
        if (step_req && step_count != '0) m_left = int'(step_count);
        else if (run_req) m_run = 1'b1;
      end
    end
  end

  function automatic int exp_state();
    if (!m_out) return 0;
    if (m_run) return 2;
    if (m_left > 0) return 3;
    return 1;
  endfunction

  always @(negedge clk) begin
    chk("state", state, exp_state());
    chk("core_rst_n", core_rst_n, m_out);
    chk("core_clk_en", core_clk_en, (m_run || m_left > 0) ? 1 : 0);
    chk("busy", busy, (exp_state() >= 2) ? 1 : 0);
    chk("step_done", step_done, m_done);
`ifdef CLK_CTRL_CYCLE_CNT_EN
    chk("cycle_count", cycle_count, m_cc);
`else
    chk("cycle_count", cycle_count, 0);
`endif
    en_cnt   += int'(core_clk_en);
    done_cnt += int'(step_done);
  end

  task tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_core_rst(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (core_rst_n) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int b_en;
  int b_done;

  initial begin
    repeat (5) tick();
    chk("reset_core_rst_n", core_rst_n, 0);
    chk("reset_state", state, 0);
    chk("reset_clk_en", core_clk_en, 0);
    rst_n = 1'b1;
    wait_core_rst(n);
    chk("hold_release_cycles", n, 2 + HOLD);
    chk("halted_after_hold", state, 1);

    b_en = en_cnt; b_done = done_cnt;
    step_count = 16'd5; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (8) tick();
    chk("step5_en_cycles", en_cnt - b_en, 5);
    chk("step5_done_pulses", done_cnt - b_done, 1);
    chk("step5_state", state, 1);
`ifdef CLK_CTRL_CYCLE_CNT_EN
    chk("step5_cycle_count", cycle_count, 5);
`endif

    b_en = en_cnt; b_done = done_cnt;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (10) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (3) tick();
    chk("run_en_cycles", en_cnt - b_en, 11);
    chk("run_done_pulses", done_cnt - b_done, 0);
    chk("run_halt_state", state, 1);
    chk("run_halt_busy", busy, 0);

    b_en = en_cnt; b_done = done_cnt;
    halt_req = 1'b1; step_req = 1'b1; run_req = 1'b1; step_count = 16'd3;
    tick();
    halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
    tick();
    chk("priority_state", state, 1);
    chk("priority_en_cycles", en_cnt - b_en, 0);

    step_count = 16'd0; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (2) tick();
    chk("zero_step_state", state, 1);
    chk("zero_step_done", done_cnt - b_done, 0);
    chk("zero_step_en", en_cnt - b_en, 0);

    b_en = en_cnt; b_done = done_cnt;
    step_count = 16'd100; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (19) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (3) tick();
    chk("abort_en_cycles", en_cnt - b_en, 20);
    chk("abort_done_pulses", done_cnt - b_done, 0);
    chk("abort_state", state, 1);

    b_done = done_cnt;
    step_count = 16'd100; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (10) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midstep_core_rst_n", core_rst_n, 0);
    chk("midstep_state", state, 0);
    chk("midstep_clk_en", core_clk_en, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_core_rst(n);
    chk("rehold_release_cycles", n, 2 + HOLD);
    chk("rehold_done_pulses", done_cnt - b_done, 0);

    b_en = en_cnt; b_done = done_cnt;
    step_count = 16'd2; step_req = 1'b1; run_req = 1'b1;
    tick();
    step_req = 1'b0; run_req = 1'b0;
    repeat (5) tick();
    chk("step_beats_run_en", en_cnt - b_en, 2);
    chk("step_beats_run_state", state, 1);

`ifdef CLK_CTRL_CYCLE_CNT_EN
    force dut.cyc_q = 32'hFFFF_FFFE;
    m_cc = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_q;
    step_count = 16'd3; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (6) tick();
    chk("wrap_cycle_count", cycle_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
